// File: rtl/rho_pkg.sv
// Shared definitions for the rho rotate engine: lane count, mode and FSM
// encodings, and the Keccak rho offset table indexed by lane = 5*y + x.
package rho_pkg;

    localparam int NUM_LANES  = 25;
    localparam int LANE_IDX_W = 5;
    localparam int RHO_W      = 6;

    typedef enum logic [1:0] {
        MODE_FWD      = 2'b00,
        MODE_INV      = 2'b01,
        MODE_PASS     = 2'b10,
        MODE_PASS_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic [RHO_W-1:0] rho_offset(input logic [LANE_IDX_W-1:0] lane);
        logic [RHO_W-1:0] r;
        case (lane)
            5'd0:  r = 6'd0;
            5'd1:  r = 6'd1;
            5'd2:  r = 6'd62;
            5'd3:  r = 6'd28;
            5'd4:  r = 6'd27;
            5'd5:  r = 6'd36;
            5'd6:  r = 6'd44;
            5'd7:  r = 6'd6;
            5'd8:  r = 6'd55;
            5'd9:  r = 6'd20;
            5'd10: r = 6'd3;
            5'd11: r = 6'd10;
            5'd12: r = 6'd43;
            5'd13: r = 6'd25;
            5'd14: r = 6'd39;
            5'd15: r = 6'd41;
            5'd16: r = 6'd45;
            5'd17: r = 6'd15;
            5'd18: r = 6'd21;
            5'd19: r = 6'd8;
            5'd20: r = 6'd18;
            5'd21: r = 6'd2;
            5'd22: r = 6'd61;
            5'd23: r = 6'd56;
            5'd24: r = 6'd14;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rho_offset_rom.sv
// Constant lookup of a lane's rho offset reduced mod DEPTH; DEPTH is a power
// of two, so the reduction is a plain truncation to ADDR_W bits.
module rho_offset_rom
    import rho_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic [LANE_IDX_W-1:0] lane_idx,
    output logic [ADDR_W-1:0]     offset
);

    assign offset = ADDR_W'(rho_offset(lane_idx));

endmodule

// File: rtl/rho_rotate_engine.sv
// Buffers a 5x5xDEPTH state slice by slice, then writes it back with each lane
// rotated along z by its rho offset (forward, inverse or pass-through).
module rho_rotate_engine
    import rho_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rotate_en,
    input  logic [1:0]           mode,
    output logic [ADDR_W-1:0]    cnt_value,
    input  logic [NUM_LANES-1:0] line_in,
    output logic                 write_enable,
    output logic [NUM_LANES-1:0] write_value,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    mode_e                  mode_q, mode_d;
    logic                   en_prev_q, en_prev_d;
    logic                   we_q, we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_LANES-1:0]   buf_q [DEPTH];
    logic [NUM_LANES-1:0]   buf_d [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        en_prev_d = rotate_en;
        we_d      = we_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        buf_d     = buf_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rotate_en && !en_prev_q) begin
                    state_d = ST_LOAD;
                    mode_d  = mode_e'(mode);
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                buf_d[cnt_q] = line_in;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // History resets high so a rotate_en already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_FWD;
            en_prev_q <= 1'b1;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            en_prev_q <= en_prev_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    logic [ADDR_W-1:0] lane_off [NUM_LANES];
    logic [ADDR_W-1:0] rd_addr  [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rho_offset_rom #(.DEPTH(DEPTH)) u_rom (
            .lane_idx (LANE_IDX_W'(i)),
            .offset   (lane_off[i])
        );

        assign rd_addr[i] = (mode_q == MODE_FWD) ? cnt_q - lane_off[i] :
                            (mode_q == MODE_INV) ? cnt_q + lane_off[i] : cnt_q;

        assign write_value[i] = we_q & buf_q[rd_addr[i]][i];
    end

    assign cnt_value    = cnt_q;
    assign write_enable = we_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rho_rotate_engine.sv
// Bench for rho_rotate_engine at DEPTH=64 and DEPTH=8: table vectors, a rho
// reference model and a write scoreboard per instance.
module tb_rho_rotate_engine;

    typedef struct {
        logic [1:0] mode;
        int         lane;
        int         slice;
        int         exp_slice;
        bit         chg;
    } vec_t;

    typedef struct {
        int          addr;
        logic [24:0] val;
    } sb_t;

    localparam int RY [5][5] = '{
        '{ 0,  1, 62, 28, 27},
        '{36, 44,  6, 55, 20},
        '{ 3, 10, 43, 25, 39},
        '{41, 45, 15, 21,  8},
        '{18,  2, 61, 56, 14}
    };

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst64, en64, we64, busy64, done64;
    logic [1:0]  mode64;
    logic [5:0]  cnt64;
    logic [24:0] line64, wv64;
    logic        rst8, en8, we8, busy8, done8;
    logic [1:0]  mode8;
    logic [2:0]  cnt8;
    logic [24:0] line8, wv8;

    logic [24:0] mem64 [64];
    logic [24:0] mem8  [64];
    logic [24:0] cap64 [64];
    logic [24:0] orig  [64];

    assign line64 = mem64[cnt64];
    assign line8  = mem8[{3'b000, cnt8}];

    rho_rotate_engine #(.DEPTH(64)) dut64 (
        .clk(clk), .rst(rst64), .rotate_en(en64), .mode(mode64), .cnt_value(cnt64),
        .line_in(line64), .write_enable(we64), .write_value(wv64), .busy(busy64), .done(done64)
    );

    rho_rotate_engine #(.DEPTH(8)) dut8 (
        .clk(clk), .rst(rst8), .rotate_en(en8), .mode(mode8), .cnt_value(cnt8),
        .line_in(line8), .write_enable(we8), .write_value(wv8), .busy(busy8), .done(done8)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt64 = 0;
    int   done_cnt64 = 0;
    sb_t  q64 [$];
    sb_t  q8  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] model_line(input logic [24:0] st [64], input int d,
                                               input logic [1:0] m, input int c);
        logic [24:0] r;
        int off, src;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            off = RY[i / 5][i % 5] % d;
            if (m == 2'b00)      src = (c - off + d) % d;
            else if (m == 2'b01) src = (c + off) % d;
            else                 src = c;
            r[i] = st[src][i];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (we64) begin
            if (q64.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_we64: write at addr %0d, none expected", cnt64);
            end else begin
                e = q64.pop_front();
                chk("addr64", 64'(cnt64), 64'(e.addr));
                chk("data64", 64'(wv64), 64'(e.val));
            end
            cap64[cnt64] = wv64;
            we_cnt64++;
        end else begin
            chk("wv64_zero_when_idle", 64'(wv64), 64'd0);
        end
        if (done64) done_cnt64++;
        if (we8) begin
            if (q8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_we8: write at addr %0d, none expected", cnt8);
            end else begin
                e = q8.pop_front();
                chk("addr8", 64'(cnt8), 64'(e.addr));
                chk("data8", 64'(wv8), 64'(e.val));
            end
        end
    end

    task automatic run64(input logic [1:0] m, input bit chg, input bit hold);
        int n;
        bit got;
        @(negedge clk);
        mode64 = m; en64 = 1'b1;
        n = 0; got = 0;
        while (!got && n < 400) begin
            @(posedge clk); #1; n++;
            if (!hold && n == 2) en64 = 1'b0;
            if (chg && n == 6) begin en64 = 1'b1; mode64 = ~m; end
            if (chg && n == 8) en64 = 1'b0;
            if (done64) got = 1;
        end
        chk("done64_latency", 64'(n), 64'd129);
        @(posedge clk); #1;
        chk("done64_single_pulse", 64'(done64), 64'd0);
        chk("queue64_drained", 64'(q64.size()), 64'd0);
        q64.delete();
        if (hold) begin
            repeat (5) @(posedge clk);
            #1;
            chk("held_en_no_restart", 64'(busy64), 64'd0);
        end
        en64 = 1'b0;
        @(posedge clk);
    endtask

    task automatic run8(input logic [1:0] m);
        int n;
        bit got;
        @(negedge clk);
        mode8 = m; en8 = 1'b1;
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 2) en8 = 1'b0;
            if (done8) got = 1;
        end
        chk("done8_latency", 64'(n), 64'd17);
        chk("queue8_drained", 64'(q8.size()), 64'd0);
        q8.delete();
        @(posedge clk);
    endtask

    initial begin
        vec_t vecs [8];
        int   w0, d0, n;

        vecs[0] = '{2'b00,  1,  0,  1, 1'b0};
        vecs[1] = '{2'b00, 24, 60, 10, 1'b0};
        vecs[2] = '{2'b00,  0,  5,  5, 1'b1};
        vecs[3] = '{2'b01,  6, 44,  0, 1'b0};
        vecs[4] = '{2'b00, 12, 30,  9, 1'b0};
        vecs[5] = '{2'b01,  3, 10, 46, 1'b1};
        vecs[6] = '{2'b10, 17, 33, 33, 1'b0};
        vecs[7] = '{2'b00,  2, 63, 61, 1'b0};

        for (int s = 0; s < 64; s++) begin mem64[s] = '0; mem8[s] = '0; end
        rst64 = 1'b1; rst8 = 1'b1; en64 = 1'b1; en8 = 1'b1; mode64 = 2'b00; mode8 = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst64 = 1'b0; rst8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_busy64",  64'(busy64), 64'd0);
        chk("reset_cnt64",   64'(cnt64),  64'd0);
        chk("reset_we64",    64'(we64),   64'd0);
        chk("reset_done64",  64'(done64), 64'd0);
        chk("reset_busy8",   64'(busy8),  64'd0);
        chk("reset_cnt8",    64'(cnt8),   64'd0);
        @(negedge clk); en64 = 1'b0; en8 = 1'b0;
        @(posedge clk);

        foreach (vecs[v]) begin
            for (int s = 0; s < 64; s++) mem64[s] = '0;
            mem64[vecs[v].slice][vecs[v].lane] = 1'b1;
            for (int c = 0; c < 64; c++)
                q64.push_back('{c, (c == vecs[v].exp_slice) ? (25'd1 << vecs[v].lane) : 25'd0});
            run64(vecs[v].mode, vecs[v].chg, 1'b0);
        end

        for (int s = 0; s < 64; s++) begin mem64[s] = 25'($urandom); orig[s] = mem64[s]; end
        for (int c = 0; c < 64; c++) q64.push_back('{c, model_line(orig, 64, 2'b00, c)});
        run64(2'b00, 1'b0, 1'b0);
        for (int s = 0; s < 64; s++) mem64[s] = cap64[s];
        for (int c = 0; c < 64; c++) q64.push_back('{c, orig[c]});
        run64(2'b01, 1'b0, 1'b0);

        for (int s = 0; s < 64; s++) begin mem64[s] = 25'($urandom); orig[s] = mem64[s]; end
        w0 = we_cnt64; d0 = done_cnt64;
        for (int c = 0; c < 64; c++) q64.push_back('{c, orig[c]});
        run64(2'b10, 1'b0, 1'b1);
        chk("pass_we_cycles", 64'(we_cnt64 - w0), 64'd64);
        chk("pass_done_pulses", 64'(done_cnt64 - d0), 64'd1);
        for (int c = 0; c < 64; c++) q64.push_back('{c, model_line(orig, 64, 2'b11, c)});
        run64(2'b11, 1'b0, 1'b0);

        // Reset in the middle of LOAD with rotate_en held high throughout.
        @(negedge clk); mode64 = 2'b00; en64 = 1'b1;
        n = 0;
        while (!(busy64 && cnt64 == 6'd20) && n < 100) begin @(posedge clk); #1; n++; end
        chk("reach_load_cnt20", 64'(cnt64), 64'd20);
        rst64 = 1'b1;
        @(posedge clk); #1;
        rst64 = 1'b0;
        chk("midrst_busy", 64'(busy64), 64'd0);
        chk("midrst_cnt",  64'(cnt64),  64'd0);
        chk("midrst_we",   64'(we64),   64'd0);
        chk("midrst_done", 64'(done64), 64'd0);
        d0 = done_cnt64;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_held_no_start", 64'(busy64), 64'd0);
        chk("midrst_no_done", 64'(done_cnt64 - d0), 64'd0);
        en64 = 1'b0;
        @(posedge clk);
        for (int s = 0; s < 64; s++) begin mem64[s] = 25'($urandom); orig[s] = mem64[s]; end
        for (int c = 0; c < 64; c++) q64.push_back('{c, model_line(orig, 64, 2'b00, c)});
        run64(2'b00, 1'b0, 1'b0);

        mem8[3][2] = 1'b1;
        for (int c = 0; c < 8; c++) q8.push_back('{c, (c == 1) ? 25'd4 : 25'd0});
        run8(2'b00);
        for (int s = 0; s < 8; s++) begin mem8[s] = 25'($urandom); orig[s] = mem8[s]; end
        for (int c = 0; c < 8; c++) q8.push_back('{c, model_line(orig, 8, 2'b00, c)});
        run8(2'b00);
        for (int c = 0; c < 8; c++) q8.push_back('{c, model_line(orig, 8, 2'b01, c)});
        run8(2'b01);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
